// File: rtl/serial_addsub_ctrl_if.sv
// Handshake and data bundle for serial_addsub_ctrl.
// master: requester/consumer side; slave: the controller.
interface serial_addsub_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             busy;

  modport master (
    output start_valid, op_a, op_b, sub, res_ready,
    input  start_ready, res_valid, result, carry, overflow, zero, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, res_ready,
    output start_ready, res_valid, result, carry, overflow, zero, busy
  );
endinterface

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller: one full adder stepped LSB first,
// one bit per cycle, WIDTH cycles per operation, valid/ready on both ends.
// Optional feature: define SERIAL_ADDSUB_SUB_EN to honour the sub input
// (two's-complement A-B); otherwise sub is ignored and only A+B is done.

// One-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_addsub_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_addsub_ctrl_if.slave   bus
);
  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             res_valid_q, res_valid_d;
  logic             start_ready_q, start_ready_d;
  logic             busy_q, busy_d;

  logic             sub_eff;
  logic             fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [WIDTH-1:0] acc_next;

  // Effective subtract request for the operation being accepted.
  always_comb begin
`ifdef SERIAL_ADDSUB_SUB_EN
    sub_eff = bus.sub;
`else
    sub_eff = bus.sub & 1'b0;
`endif
  end

  // Bit-slice selection for the current RUN cycle.
  always_comb begin
    fa_a   = a_q[cnt_q];
    fa_b   = b_q[cnt_q] ^ sub_q;
    fa_cin = cy_q;
  end

  full_adder u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (fa_cin),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state and datapath update. The visible result/flags are only
  // replaced on the last bit-cycle so they hold the previous result during RUN.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cy_d       = cy_q;
    sub_d      = sub_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    acc_next        = acc_q;
    acc_next[cnt_q] = fa_s;

    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          state_d = RUN;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          sub_d   = sub_eff;
          cnt_d   = '0;
          cy_d    = sub_eff;
        end
      end
      RUN: begin
        acc_d = acc_next;
        cy_d  = fa_cout;
        if (cnt_q == CNT_LAST) begin
          state_d    = DONE;
          result_d   = acc_next;
          carry_d    = fa_cout;
          overflow_d = fa_cin ^ fa_cout;
          zero_d     = (acc_next == '0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    res_valid_d   = (state_d == DONE);
    start_ready_d = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cy_q          <= 1'b0;
      sub_q         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      result_q      <= '0;
      carry_q       <= 1'b0;
      overflow_q    <= 1'b0;
      zero_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cy_q          <= cy_d;
      sub_q         <= sub_d;
      a_q           <= a_d;
      b_q           <= b_d;
      acc_q         <= acc_d;
      result_q      <= result_d;
      carry_q       <= carry_d;
      overflow_q    <= overflow_d;
      zero_q        <= zero_d;
      res_valid_q   <= res_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.start_ready = start_ready_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.result      = result_q;
  assign bus.carry       = carry_q;
  assign bus.overflow    = overflow_q;
  assign bus.zero        = zero_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Testbench for serial_addsub_ctrl: directed corner cases plus random
// operations checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_addsub_ctrl;
  localparam int unsigned WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_addsub_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_addsub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [WIDTH-1:0] last_res;
  logic             last_c, last_o, last_z;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, output logic [WIDTH-1:0] r,
                                output logic c, output logic o, output logic z);
    longint ua, ub, sa, sb, sr, full;
    logic   eff;
`ifdef SERIAL_ADDSUB_SUB_EN
    eff = s;
`else
    eff = s & 1'b0;
`endif
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (eff) begin
      full = ua - ub;
      c    = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub;
      c    = (full >= (longint'(1) << WIDTH));
      sr   = sa + sb;
    end
    r = WIDTH'(full);
    o = (sr > ((longint'(1) << (WIDTH - 1)) - 1)) || (sr < -(longint'(1) << (WIDTH - 1)));
    z = (r == '0);
  endfunction

  function automatic logic [63:0] pack_out();
    return 64'({bus.res_valid, bus.carry, bus.overflow, bus.zero, bus.result});
  endfunction

  // One full operation; called and returning on a falling edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                        input int unsigned stall, input bit sv_hold);
    logic [WIDTH-1:0] er;
    logic             ec, eo, ez;
    int unsigned      cyc;
    logic [63:0]      exp_pk;
    model(a, b, s, er, ec, eo, ez);
    cyc = 0;
    while (!bus.start_ready && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    check("start_ready_idle", 64'(bus.start_ready), 64'd1);
    bus.start_valid = 1'b1;
    bus.op_a        = a;
    bus.op_b        = b;
    bus.sub         = s;
    @(posedge clk);
    @(negedge clk);
    check("busy_run", 64'(bus.busy), 64'd1);
    check("start_ready_run", 64'(bus.start_ready), 64'd0);
    check("result_hold_run", 64'({bus.res_valid, bus.carry, bus.overflow, bus.zero, bus.result}),
          64'({1'b0, last_c, last_o, last_z, last_res}));
    if (sv_hold) begin
      bus.op_a = WIDTH'($urandom);
      bus.op_b = WIDTH'($urandom);
      bus.sub  = 1'($urandom_range(0, 1));
    end else begin
      bus.start_valid = 1'b0;
    end
    cyc = 0;
    while (!bus.res_valid && cyc < WIDTH + 8) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check("latency", 64'(cyc), 64'(WIDTH));
    check("result", 64'(bus.result), 64'(er));
    check("carry", 64'(bus.carry), 64'(ec));
    check("overflow", 64'(bus.overflow), 64'(eo));
    check("zero", 64'(bus.zero), 64'(ez));
    exp_pk = 64'({1'b1, ec, eo, ez, er});
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk);
      check("done_stable", pack_out(), exp_pk);
      check("start_ready_done", 64'(bus.start_ready), 64'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("after_handshake", 64'({bus.res_valid, bus.busy, bus.start_ready}), 64'(3'b001));
    check("result_kept", pack_out(), 64'({1'b0, ec, eo, ez, er}));
    last_res = er;
    last_c   = ec;
    last_o   = eo;
    last_z   = ez;
  endtask

  task automatic mid_run_reset();
    bit seen_valid;
    bus.start_valid = 1'b1;
    bus.op_a        = 32'h1234_5678;
    bus.op_b        = 32'h0FED_CBA9;
    bus.sub         = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          64'({bus.res_valid, bus.busy, bus.start_ready, bus.carry, bus.overflow, bus.zero, bus.result}),
          64'({3'b001, 3'b000, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      seen_valid = seen_valid | bus.res_valid | bus.busy;
    end
    check("no_result_after_reset", 64'(seen_valid), 64'd0);
    last_res = '0;
    last_c   = 1'b0;
    last_o   = 1'b0;
    last_z   = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    int unsigned      pick;
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.op_a        = '0;
    bus.op_b        = '0;
    bus.sub         = 1'b0;
    bus.res_ready   = 1'b0;
    last_res        = '0;
    last_c          = 1'b0;
    last_o          = 1'b0;
    last_z          = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          64'({bus.res_valid, bus.busy, bus.start_ready, bus.carry, bus.overflow, bus.zero, bus.result}),
          64'({3'b001, 3'b000, 32'h0}));
    rst_n = 1'b1;

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 2, 1'b0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, 1'b0);
    run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 5, 1'b1);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
    run_op(32'h0000_0003, 32'h0000_0005, 1'b1, 0, 1'b0);

    mid_run_reset();
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, 1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      pick = $urandom_range(0, 5);
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      if (pick == 0) rb = ra;
      if (pick == 1) ra = 32'h8000_0000;
      if (pick == 2) rb = 32'hFFFF_FFFF;
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    bus.start_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub_ctrl.md
SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, meaning operand/result width in bits; legal range 2..64.
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port start_valid  input  1  requester presents operands.
REQ-005 SHALL provide port start_ready  output  1  controller can accept operands.
REQ-006 SHALL provide ports op_a, op_b  input  WIDTH  operands, sampled only on start handshake.
REQ-007 SHALL provide port sub  input  1  subtract request, sampled on start handshake.
REQ-008 SHALL provide port res_valid  output  1  result and flags valid.
REQ-009 SHALL provide port res_ready  input  1  consumer accepts result.
REQ-010 SHALL provide port result  output  WIDTH  sum/difference.
REQ-011 SHALL provide ports carry, overflow, zero  output  1 each  carry-out of MSB, signed overflow, result==0.
REQ-012 SHALL provide port busy  output  1  high in RUN or DONE.

Function
REQ-013 SHALL sequence exactly one instance of the team's one-bit full adder (a, b, cin -> s, cout), one bit per cycle, LSB first; no other adder logic.
REQ-014 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start_valid&&start_ready; RUN->DONE after WIDTH bit-cycles; DONE->IDLE on res_valid&&res_ready.
REQ-015 SHALL drive start_ready=1 only in IDLE; start_valid in RUN/DONE ignored, no operand capture.
REQ-016 On accept: latch op_a, op_b, effective sub; clear bit counter to 0; load carry register with effective sub.
REQ-017 Each RUN cycle i: adder a=A[i], b=B[i]^sub_eff, cin=carry reg; s stored to result bit i; carry reg<=cout; counter+1.
REQ-018 Counter SHALL be $clog2(WIDTH) bits wide, terminate at WIDTH-1 without wrap into a further bit-cycle.
REQ-019 Latency: accept at edge N -> res_valid high after edge N+WIDTH (WIDTH RUN cycles), fixed, independent of data.
REQ-020 carry = final cout; overflow = cin XOR cout of MSB bit-cycle; zero = (result==0).
REQ-021 In DONE, result/carry/overflow/zero/res_valid SHALL hold stable until res_ready; backpressure unlimited.
REQ-022 DONE with res_ready and start_valid both high: return to IDLE; new request accepted at earliest the following cycle.
REQ-023 Outside DONE, res_valid=0; result and flags hold last completed values.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, counter 0, carry reg 0, result 0, carry/overflow/zero 0, res_valid 0, busy 0, start_ready 1.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the operation; no partial result emitted after release.
REQ-026 First accept possible on first rising edge with rst_n high.

Configuration
REQ-027 Macro SERIAL_ADDSUB_SUB_EN defined: sub honoured per REQ-016/017 (two's-complement A-B, carry=1 means no borrow).
REQ-028 Macro undefined: sub port present but ignored, sub_eff=0, block performs addition only.

Verification
REQ-029 WIDTH=32: 0x00000005+0x00000003 -> result 0x00000008, carry 0, overflow 0, zero 0, res_valid exactly 32 cycles after accept.
REQ-030 0xFFFFFFFF+0x00000001 -> result 0x00000000, carry 1, overflow 0, zero 1.
REQ-031 0x7FFFFFFF+0x00000001 -> result 0x80000000, carry 0, overflow 1, zero 0.
REQ-032 res_ready low 5 cycles in DONE, start_valid held high -> outputs stable, start_ready 0; second request accepted 1 cycle after result handshake.
REQ-033 rst_n pulsed low at RUN cycle 10 -> all outputs at reset values, start_ready 1, no res_valid afterwards until a new request completes.
REQ-034 With SERIAL_ADDSUB_SUB_EN: 5-3 -> 0x00000002, carry 1; 0x80000000-1 -> 0x7FFFFFFF, overflow 1; without macro sub=1, 5,3 -> 0x00000008.
